// File: rtl/execute_cc_stage_if.sv
// rtl/execute_cc_stage_if.sv - decode-to-execute and execute-to-memory handshake bundle
interface execute_cc_stage_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_icode;
    logic [3:0]       in_ifun;
    logic [WIDTH-1:0] in_vala;
    logic [WIDTH-1:0] in_valb;
    logic [WIDTH-1:0] in_valc;
    logic [3:0]       in_dste;
    logic             in_set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_icode;
    logic [WIDTH-1:0] out_vale;
    logic [WIDTH-1:0] out_vala;
    logic [3:0]       out_dste;
    logic             out_cnd;
    logic [2:0]       cc;

    modport slave (
        input  flush, in_valid, in_icode, in_ifun, in_vala, in_valb, in_valc,
               in_dste, in_set_cc, out_ready,
        output in_ready, out_valid, out_icode, out_vale, out_vala, out_dste,
               out_cnd, cc
    );

    modport master (
        output flush, in_valid, in_icode, in_ifun, in_vala, in_valb, in_valc,
               in_dste, in_set_cc, out_ready,
        input  in_ready, out_valid, out_icode, out_vale, out_vala, out_dste,
               out_cnd, cc
    );
endinterface

// File: rtl/execute_cc_stage.sv
// rtl/execute_cc_stage.sv - Y86-64 execute stage with ALU, condition codes and output register
module execute_cc_stage #(
    parameter int         WIDTH      = 32,
    parameter logic [2:0] CC_RESET   = 3'b100,
    parameter int         STACK_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    execute_cc_stage_if.slave bus
);
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    logic             accept;
    logic             cc_we;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       alu_ctl;
    logic [WIDTH-1:0] ans;
    logic             ovf;
    logic             cnd;
    logic [3:0]       dste_nxt;
    logic             zf, sf, of;

    logic             out_valid_q;
    logic [3:0]       out_icode_q;
    logic [WIDTH-1:0] out_vale_q;
    logic [WIDTH-1:0] out_vala_q;
    logic [3:0]       out_dste_q;
    logic             out_cnd_q;
    logic [2:0]       cc_q;

    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
    assign cc_we        = accept & (bus.in_icode == I_OPQ) & bus.in_set_cc & (bus.in_ifun <= 4'd3);
    assign {zf, sf, of} = cc_q;

    // op_a/op_b are aluA/aluB; the ALU result is always aluB OP aluA.
    always_comb begin
        op_a    = '0;
        op_b    = '0;
        alu_ctl = 2'b00;
        case (bus.in_icode)
            I_OPQ: begin
                op_a    = bus.in_vala;
                op_b    = bus.in_valb;
                alu_ctl = bus.in_ifun[1:0];
            end
            I_RRMOV:          op_a = bus.in_vala;
            I_IRMOV:          op_a = bus.in_valc;
            I_RMMOV, I_MRMOV: begin
                op_a = bus.in_valc;
                op_b = bus.in_valb;
            end
            I_CALL, I_PUSH: begin
                op_a = -STEP;
                op_b = bus.in_valb;
            end
            I_RET, I_POP: begin
                op_a = STEP;
                op_b = bus.in_valb;
            end
            default: ;
        endcase
    end

    always_comb begin
        ans = '0;
        ovf = 1'b0;
        case (alu_ctl)
            2'b00: begin
                ans = op_b + op_a;
                ovf = (op_b[WIDTH-1] == op_a[WIDTH-1]) && (ans[WIDTH-1] != op_b[WIDTH-1]);
            end
            2'b01: begin
                ans = op_b - op_a;
                ovf = (op_b[WIDTH-1] != op_a[WIDTH-1]) && (ans[WIDTH-1] != op_b[WIDTH-1]);
            end
            2'b10:   ans = op_b & op_a;
            default: ans = op_b ^ op_a;
        endcase
    end

    // Conditions read the pre-update cc; an OPq in the previous cycle has already landed.
    always_comb begin
        cnd = 1'b0;
        if (bus.in_icode == I_RRMOV || bus.in_icode == I_JXX) begin
            case (bus.in_ifun)
                4'd0:    cnd = 1'b1;
                4'd1:    cnd = (sf ^ of) | zf;
                4'd2:    cnd = sf ^ of;
                4'd3:    cnd = zf;
                4'd4:    cnd = ~zf;
                4'd5:    cnd = ~(sf ^ of);
                4'd6:    cnd = ~(sf ^ of) & ~zf;
                default: cnd = 1'b0;
            endcase
        end
    end

    assign dste_nxt = (bus.in_icode == I_RRMOV && !cnd) ? 4'hF : bus.in_dste;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_vale_q  <= '0;
            out_vala_q  <= '0;
            out_dste_q  <= 4'hF;
            out_cnd_q   <= 1'b0;
            cc_q        <= CC_RESET;
        end else begin
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_icode_q <= bus.in_icode;
                out_vale_q  <= ans;
                out_vala_q  <= bus.in_vala;
                out_dste_q  <= dste_nxt;
                out_cnd_q   <= cnd;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (cc_we) begin
                cc_q <= {ans == '0, ans[WIDTH-1], ovf};
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_icode = out_icode_q;
    assign bus.out_vale  = out_vale_q;
    assign bus.out_vala  = out_vala_q;
    assign bus.out_dste  = out_dste_q;
    assign bus.out_cnd   = out_cnd_q;
    assign bus.cc        = cc_q;
endmodule

// File: tb/tb_execute_cc_stage.sv
// tb/tb_execute_cc_stage.sv - scoreboard bench for execute_cc_stage
`timescale 1ns/1ps
module tb_execute_cc_stage;
    typedef struct packed {
        logic [3:0]  icode;
        logic [31:0] vale;
        logic [31:0] vala;
        logic [3:0]  dste;
        logic        cnd;
        logic [2:0]  cc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    execute_cc_stage_if #(.WIDTH(32)) bus();

    execute_cc_stage #(.WIDTH(32), .CC_RESET(3'b100), .STACK_STEP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [31:0] vala, input logic [31:0] valb,
                        input logic [31:0] valc, input logic [3:0] dste,
                        input logic set_cc, input logic [31:0] e_vale,
                        input logic [3:0] e_dste, input logic e_cnd, input logic [2:0] e_cc);
        int   n;
        exp_t e;
        bus.in_icode  = icode;
        bus.in_ifun   = ifun;
        bus.in_vala   = vala;
        bus.in_valb   = valb;
        bus.in_valc   = valc;
        bus.in_dste   = dste;
        bus.in_set_cc = set_cc;
        bus.in_valid  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck at 0 for icode %h", icode);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        e = '{icode: icode, vale: e_vale, vala: vala, dste: e_dste, cnd: e_cnd, cc: e_cc};
        sb.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    // Monitor: every handed-off result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: vale %h with empty scoreboard", bus.out_vale);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_icode", {28'h0, bus.out_icode}, {28'h0, e.icode});
                check("out_vale", bus.out_vale, e.vale);
                check("out_vala", bus.out_vala, e.vala);
                check("out_dste", {28'h0, bus.out_dste}, {28'h0, e.dste});
                check("out_cnd", {31'h0, bus.out_cnd}, {31'h0, e.cnd});
                check("cc", {29'h0, bus.cc}, {29'h0, e.cc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_icode = '0;
        bus.in_ifun = '0;
        bus.in_vala = '0;
        bus.in_valb = '0;
        bus.in_valc = '0;
        bus.in_dste = 4'hF;
        bus.in_set_cc = 1'b1;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_dste", {28'h0, bus.out_dste}, 32'hF);
        check("rst_out_vale", bus.out_vale, 32'h0);
        check("rst_out_icode", {28'h0, bus.out_icode}, 32'h0);
        check("rst_cc", {29'h0, bus.cc}, 32'h4);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // icode ifun valA valB valC dste set_cc | vale dste cnd cc
        send(4'h6, 4'h1, 32'd5, 32'd3, 32'h0, 4'h2, 1'b1, 32'hFFFF_FFFE, 4'h2, 1'b0, 3'b010);
        send(4'h6, 4'h0, 32'd1, 32'h7FFF_FFFF, 32'h0, 4'h2, 1'b1, 32'h8000_0000, 4'h2, 1'b0, 3'b011);
        send(4'h6, 4'h1, 32'd1, 32'd1, 32'h0, 4'h2, 1'b0, 32'h0, 4'h2, 1'b0, 3'b011);
        send(4'h6, 4'h1, 32'd7, 32'd7, 32'h0, 4'h1, 1'b1, 32'h0, 4'h1, 1'b0, 3'b100);
        send(4'h2, 4'h3, 32'h1234, 32'h0, 32'h0, 4'h3, 1'b1, 32'h1234, 4'h3, 1'b1, 3'b100);
        send(4'h2, 4'h4, 32'h1234, 32'h0, 32'h0, 4'h3, 1'b1, 32'h1234, 4'hF, 1'b0, 3'b100);
        send(4'h7, 4'h1, 32'h0, 32'h0, 32'h400, 4'hF, 1'b1, 32'h0, 4'hF, 1'b1, 3'b100);
        send(4'h6, 4'h3, 32'h8000_0000, 32'h0000_00FF, 32'h0, 4'h5, 1'b1, 32'h8000_00FF, 4'h5, 1'b0, 3'b010);
        send(4'h6, 4'h6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 4'h5, 1'b1, 32'h0000_F000, 4'h5, 1'b0, 3'b010);
        send(4'h7, 4'h7, 32'h0, 32'h0, 32'h400, 4'hF, 1'b1, 32'h0, 4'hF, 1'b0, 3'b010);
        send(4'h3, 4'h0, 32'h0, 32'h0, 32'h42, 4'h6, 1'b1, 32'h42, 4'h6, 1'b0, 3'b010);
        send(4'h5, 4'h0, 32'h0, 32'h100, 32'h8, 4'h7, 1'b1, 32'h108, 4'h7, 1'b0, 3'b010);
        send(4'hB, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 1'b1, 32'h108, 4'h4, 1'b0, 3'b010);
        send(4'h8, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 1'b1, 32'hF8, 4'h4, 1'b0, 3'b010);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: first add is held while the second waits on in_ready.
        bus.out_ready = 1'b0;
        send(4'h6, 4'h0, 32'd1, 32'd2, 32'h0, 4'h1, 1'b1, 32'd3, 4'h1, 1'b0, 3'b000);
        fork
            send(4'h6, 4'h0, 32'd3, 32'd4, 32'h0, 4'h2, 1'b1, 32'd7, 4'h2, 1'b0, 3'b000);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
                    check("hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
                    check("hold_out_vale", bus.out_vale, 32'd3);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Flush kills an OPq that would have set ZF.
        bus.in_icode = 4'h6;
        bus.in_ifun = 4'h1;
        bus.in_vala = 32'd7;
        bus.in_valb = 32'd7;
        bus.in_set_cc = 1'b1;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        check("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("flush_cc", {29'h0, bus.cc}, 32'h0);
        @(posedge clk);
        #1;

        // Asynchronous reset while a result is held.
        bus.out_ready = 1'b0;
        send(4'h6, 4'h1, 32'd5, 32'd3, 32'h0, 4'h2, 1'b1, 32'hFFFF_FFFE, 4'h2, 1'b0, 3'b010);
        #2;
        check("pre_rst_out_valid", {31'h0, bus.out_valid}, 32'h1);
        check("pre_rst_cc", {29'h0, bus.cc}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("async_out_dste", {28'h0, bus.out_dste}, 32'hF);
        check("async_cc", {29'h0, bus.cc}, 32'h4);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4'hA, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 1'b1, 32'hF8, 4'h4, 1'b0, 3'b100);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("sb_drained", sb.size(), 32'h0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
